// File: rtl/usb_tx_line_encoder.sv
// USB full-speed transmit line encoder.
// Serializes bytes LSB first with bit stuffing and NRZI, drives D+/D-,
// and terminates each packet with SE0,SE0,J.
module usb_tx_line_encoder #(
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       d_plus,
    output logic       d_minus,
    output logic       tx_busy,
    output logic       eop_done,
    output logic       tx_err
);

    localparam int unsigned   TW     = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_STUFF,
        S_EOP_SE0,
        S_EOP_J
    } state_t;

    state_t        r_state;
    logic [7:0]    r_hold;
    logic          r_hold_full;
    logic          r_hold_last;
    logic [7:0]    r_shift;
    logic [2:0]    r_bit_idx;
    logic          r_last;
    logic          r_pend;       // byte loaded from IDLE, first bit not yet on the line
    logic [2:0]    r_ones;
    logic [TW-1:0] r_timer;
    logic          r_eop_cnt;
    logic          r_level;      // 1 = J, 0 = K for the most recent non-SE0 bit
    logic          r_dp;
    logic          r_dm;
    logic          r_busy;
    logic          r_eop_done;
    logic          r_err;

    logic       w_bit_end;
    logic       w_sending;
    logic       w_acc_hold;
    logic       w_stuff_now;
    logic       w_adv;
    logic       w_byte_end;
    logic       w_load;
    logic       w_take_hold;
    logic       w_bypass;
    logic       w_next_bit;
    logic       w_next_level;
    logic [2:0] w_next_ones;

    // Bit-boundary decode and next-bit selection
    always_comb begin
        w_bit_end   = (r_timer == T_LAST);
        w_sending   = (r_state == S_SEND) || (r_state == S_STUFF);
        // STUFF is part of the sending phase, so the holding register stays open
        // there; otherwise tx_ready=1 would be presented without an accept.
        w_acc_hold  = w_sending && tx_valid && !r_hold_full;
        w_stuff_now = (r_state == S_SEND) && !r_pend && (r_ones == 3'd6);
        w_adv       = w_sending && w_bit_end && !w_stuff_now;
        w_byte_end  = !r_pend && (r_bit_idx == 3'd7);
        w_load      = w_byte_end && !r_last && (r_hold_full || w_acc_hold);
        w_take_hold = w_adv && w_byte_end && !r_last && r_hold_full;
        // A byte arriving exactly at an empty-holding byte boundary goes straight
        // to the shift register instead of causing an underrun.
        w_bypass    = w_adv && w_byte_end && !r_last && !r_hold_full && w_acc_hold;

        if (r_pend) begin
            w_next_bit = r_shift[0];
        end else if (!w_byte_end) begin
            w_next_bit = r_shift[1];
        end else if (r_hold_full) begin
            w_next_bit = r_hold[0];
        end else begin
            w_next_bit = tx_data[0];
        end

        w_next_level = w_next_bit ? r_level : ~r_level;
        if (!w_next_bit) begin
            w_next_ones = '0;
        end else if (r_ones == 3'd6) begin
            w_next_ones = r_ones;
        end else begin
            w_next_ones = r_ones + 3'd1;
        end
    end

    // Line FSM: bit timer, shifting, stuffing, NRZI, EOP and holding register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_hold_last <= 1'b0;
            r_shift     <= '0;
            r_bit_idx   <= '0;
            r_last      <= 1'b0;
            r_pend      <= 1'b0;
            r_ones      <= '0;
            r_timer     <= '0;
            r_eop_cnt   <= 1'b0;
            r_level     <= 1'b1;
            r_dp        <= 1'b1;
            r_dm        <= 1'b0;
            r_busy      <= 1'b0;
            r_eop_done  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_eop_done <= 1'b0;
            r_err      <= 1'b0;

            if (r_state == S_IDLE) begin
                r_timer <= '0;
            end else if (w_bit_end) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end

            unique case (r_state)
                S_IDLE: begin
                    if (tx_valid) begin
                        r_state   <= S_SEND;
                        r_shift   <= tx_data;
                        r_last    <= tx_last;
                        r_bit_idx <= '0;
                        r_ones    <= '0;
                        r_pend    <= 1'b1;
                        // force a boundary on the next edge so bit 0 starts there
                        r_timer   <= T_LAST;
                    end
                end

                S_SEND, S_STUFF: begin
                    if (w_bit_end) begin
                        if (w_stuff_now) begin
                            r_state <= S_STUFF;
                            r_level <= ~r_level;
                            r_dp    <= ~r_level;
                            r_dm    <= r_level;
                            r_ones  <= '0;
                        end else if (r_pend || !w_byte_end || w_load) begin
                            if (w_load) begin
                                r_shift   <= r_hold_full ? r_hold : tx_data;
                                r_last    <= r_hold_full ? r_hold_last : tx_last;
                                r_bit_idx <= '0;
                            end else if (!r_pend) begin
                                r_shift   <= {1'b0, r_shift[7:1]};
                                r_bit_idx <= r_bit_idx + 3'd1;
                            end
                            r_pend  <= 1'b0;
                            r_state <= S_SEND;
                            r_busy  <= 1'b1;
                            r_level <= w_next_level;
                            r_dp    <= w_next_level;
                            r_dm    <= ~w_next_level;
                            r_ones  <= w_next_ones;
                        end else begin
                            r_err     <= !r_last;
                            r_state   <= S_EOP_SE0;
                            r_eop_cnt <= 1'b0;
                            r_dp      <= 1'b0;
                            r_dm      <= 1'b0;
                        end
                    end
                end

                S_EOP_SE0: begin
                    if (w_bit_end) begin
                        if (!r_eop_cnt) begin
                            r_eop_cnt <= 1'b1;
                        end else begin
                            r_state <= S_EOP_J;
                            r_level <= 1'b1;
                            r_dp    <= 1'b1;
                            r_dm    <= 1'b0;
                        end
                    end
                end

                S_EOP_J: begin
                    if (w_bit_end) begin
                        r_state    <= S_IDLE;
                        r_busy     <= 1'b0;
                        r_eop_done <= 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // Holding register. A byte accepted after the final byte has no
            // packet to join, so it is dropped when the line returns to IDLE.
            if (w_acc_hold && !w_bypass) begin
                r_hold      <= tx_data;
                r_hold_last <= tx_last;
                r_hold_full <= 1'b1;
            end else if (w_take_hold) begin
                r_hold_full <= 1'b0;
            end else if ((r_state == S_EOP_J) && w_bit_end) begin
                r_hold_full <= 1'b0;
            end
        end
    end

    assign tx_ready = !r_hold_full;
    assign d_plus   = r_dp;
    assign d_minus  = r_dm;
    assign tx_busy  = r_busy;
    assign eop_done = r_eop_done;
    assign tx_err   = r_err;

endmodule

// File: tb/tb_usb_tx_line_encoder.sv
// Directed bench for usb_tx_line_encoder: per-bit line symbols, timing and pulses.
module tb_usb_tx_line_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic       tx_ready;
    logic       d_plus;
    logic       d_minus;
    logic       tx_busy;
    logic       eop_done;
    logic       tx_err;

    usb_tx_line_encoder #(.CLKS_PER_BIT(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_last  (tx_last),
        .tx_ready (tx_ready),
        .d_plus   (d_plus),
        .d_minus  (d_minus),
        .tx_busy  (tx_busy),
        .eop_done (eop_done),
        .tx_err   (tx_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // monitor: symbols while busy, pulse counts, sampled 1 time unit after the edge
    logic [1:0] sym [0:1023];
    int nsym    = 0;
    int eop_cnt = 0;
    int err_cnt = 0;
    int overlap = 0;

    always @(posedge clk) begin
        #1;
        if (tx_busy) begin
            if (nsym < 1024) sym[nsym] = {d_plus, d_minus};
            nsym++;
        end
        if (eop_done) eop_cnt++;
        if (tx_err) err_cnt++;
        if (eop_done && tx_busy) overlap++;
    end

    task automatic mon_clear();
        nsym    = 0;
        eop_cnt = 0;
        err_cnt = 0;
        overlap = 0;
    endtask

    function automatic int code_of(input byte c);
        if (c == "J") return 2;
        if (c == "K") return 1;
        return 0;
    endfunction

    // present one byte at a negedge; it is taken at the following posedge
    task automatic put_byte(input logic [7:0] d, input logic last);
        int n;
        n = 0;
        while (!tx_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) check("ready timeout", 0, 1);
        tx_data  = d;
        tx_last  = last;
        tx_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_eop(input string tag);
        for (int i = 0; i < 600; i++) begin
            if (eop_cnt > 0) break;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check({tag, " eop_done count"}, eop_cnt, 1);
        check({tag, " eop/busy overlap"}, overlap, 0);
        check({tag, " idle line"}, {30'd0, d_plus, d_minus}, 2);
    endtask

    // J=2, K=1, S(SE0)=0 per bit; every one of the 8 samples in a bit must match
    task automatic check_line(input string tag, input string exp);
        int wrong;
        int nb;
        nb    = exp.len();
        wrong = 0;
        check({tag, " busy cycles"}, nsym, nb * 8);
        for (int b = 0; b < nb; b++) begin
            check($sformatf("%s bit%0d", tag, b), int'(sym[b * 8 + 4]), code_of(exp[b]));
            for (int c = 0; c < 8; c++) begin
                if (int'(sym[b * 8 + c]) != code_of(exp[b])) wrong++;
            end
        end
        check({tag, " unstable samples"}, wrong, 0);
    endtask

    initial begin
        // 1: reset held 3 cycles
        repeat (3) @(negedge clk);
        check("rst line", {30'd0, d_plus, d_minus}, 2);
        check("rst ready", int'(tx_ready), 1);
        check("rst busy", int'(tx_busy), 0);
        check("rst eop_done", int'(eop_done), 0);
        check("rst err", int'(tx_err), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle ready", int'(tx_ready), 1);
        check("idle line", {30'd0, d_plus, d_minus}, 2);

        // 2: single byte 0x80, last
        mon_clear();
        put_byte(8'h80, 1'b1);
        tx_valid = 1'b0;
        check("t2 busy at accept+1", int'(tx_busy), 0);
        check("t2 line at accept+1", {30'd0, d_plus, d_minus}, 2);
        @(negedge clk);
        check("t2 busy at bit0", int'(tx_busy), 1);
        wait_eop("t2");
        check_line("t2", "KJKJKJKKSSJ");
        check("t2 err", err_cnt, 0);

        // 3: 0xFF, last: six ones then a stuff bit
        mon_clear();
        put_byte(8'hFF, 1'b1);
        tx_valid = 1'b0;
        wait_eop("t3");
        check_line("t3", "JJJJJJKKKSSJ");
        check("t3 err", err_cnt, 0);

        // 4: back-to-back 0x80, 0x3F(last); ones run crosses the byte boundary
        mon_clear();
        put_byte(8'h80, 1'b0);
        put_byte(8'h3F, 1'b1);
        check("t4 ready while holding full", int'(tx_ready), 0);
        tx_valid = 1'b0;
        wait_eop("t4");
        check_line("t4", {"KJKJKJKK", "KKKKKJJKJ", "SSJ"});
        check("t4 err", err_cnt, 0);

        // 5: 0x00 not last, nothing follows: underrun
        mon_clear();
        put_byte(8'h00, 1'b0);
        tx_valid = 1'b0;
        wait_eop("t5");
        check_line("t5", "KJKJKJKJSSJ");
        check("t5 err pulses", err_cnt, 1);

        // 6: reset in the middle of byte 2, then a clean packet
        mon_clear();
        put_byte(8'h80, 1'b0);
        put_byte(8'h3F, 1'b1);
        tx_valid = 1'b0;
        repeat (75) @(negedge clk);
        check("t6 busy before rst", int'(tx_busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check("t6 rst line", {30'd0, d_plus, d_minus}, 2);
        check("t6 rst busy", int'(tx_busy), 0);
        check("t6 rst ready", int'(tx_ready), 1);
        rst = 1'b0;
        @(negedge clk);
        mon_clear();
        put_byte(8'h80, 1'b1);
        tx_valid = 1'b0;
        wait_eop("t6b");
        check_line("t6b", "KJKJKJKKSSJ");
        check("t6b err", err_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
